// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states
// and the size/offset to byte-enable mapping.
package dmem_resp_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // size: 0 = byte, 1 = half, other = word; off = addr[1:0]
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: byte-enable write, synchronous read. A read only
// happens when en=1 and we=0, so rdata holds between loads.
module dmem_ram #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Memory-stage data-memory responder: IDLE/WAIT/DONE handshake around a word
// RAM with RISC-V byte/half/word sizing, alignment checks and load extension.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemReadyM,
  output logic        ErrM,
  output logic        StallM
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t        state;
  logic [2:0]    cnt;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    f3_q;
  logic          we_q;

  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic [2:0]    cur_f3;
  logic          cur_we;
  logic          cur_err;
  logic          done_edge;
  logic [31:0]   lane_wdata;
  logic [31:0]   ram_rdata;

  // Describes the word held in ram_rdata; ld_zero forces ReadDataM to 0
  logic [2:0]    ld_f3;
  logic [1:0]    ld_off;
  logic          ld_zero;

  logic          unused_hi;
  assign unused_hi = ^ALUResultM[31:AW+2];

  // With zero wait states the access completes on the accepting edge, so the
  // live inputs are used in IDLE and the latched copy afterwards.
  always_comb begin
    cur_addr  = (state == S_IDLE) ? ALUResultM[AW+1:0] : addr_q;
    cur_wdata = (state == S_IDLE) ? WriteDataM         : wdata_q;
    cur_f3    = (state == S_IDLE) ? Funct3M            : f3_q;
    cur_we    = (state == S_IDLE) ? MemWriteM          : we_q;

    case (cur_f3)
      F3_B:    cur_err = 1'b0;
      F3_H:    cur_err = cur_addr[0];
      F3_W:    cur_err = |cur_addr[1:0];
      F3_BU:   cur_err = cur_we;
      F3_HU:   cur_err = cur_we | cur_addr[0];
      default: cur_err = 1'b1;
    endcase

    case (cur_f3[1:0])
      2'd0:    lane_wdata = {4{cur_wdata[7:0]}};
      2'd1:    lane_wdata = {2{cur_wdata[15:0]}};
      default: lane_wdata = cur_wdata;
    endcase

    done_edge = !reset &&
                (((state == S_IDLE) && MemReqM && (WAIT_STATES == 0)) ||
                 ((state == S_WAIT) && (cnt == 3'd1)));
  end

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .en    (done_edge && !cur_err),
    .we    (cur_we),
    .be    (byte_en(cur_f3[1:0], cur_addr[1:0])),
    .idx   (cur_addr[AW+1:2]),
    .wdata (lane_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      MemReadyM <= 1'b0;
      ErrM      <= 1'b0;
      ld_f3     <= F3_W;
      ld_off    <= '0;
      ld_zero   <= 1'b1;
    end else begin
      MemReadyM <= done_edge;
      ErrM      <= done_edge && cur_err;
      if (done_edge) begin
        if (cur_err) begin
          ld_zero <= 1'b1;
        end else if (!cur_we) begin
          ld_zero <= 1'b0;
          ld_f3   <= cur_f3;
          ld_off  <= cur_addr[1:0];
        end
      end
      case (state)
        S_IDLE: if (MemReqM) begin
          addr_q  <= ALUResultM[AW+1:0];
          wdata_q <= WriteDataM;
          f3_q    <= Funct3M;
          we_q    <= MemWriteM;
          cnt     <= 3'(WAIT_STATES);
          state   <= (WAIT_STATES == 0) ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Extension runs off registered state only, so ReadDataM changes only at the
  // edge that enters DONE (or at reset).
  logic [31:0] shifted;
  logic [15:0] half;
  always_comb begin
    shifted = ram_rdata >> {ld_off, 3'b000};
    half    = ld_off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (ld_f3)
      F3_B:    ReadDataM = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ReadDataM = {24'h0, shifted[7:0]};
      F3_H:    ReadDataM = {{16{half[15]}}, half};
      F3_HU:   ReadDataM = {16'h0, half};
      default: ReadDataM = ram_rdata;
    endcase
    if (ld_zero) ReadDataM = '0;
  end

  assign StallM = MemReqM && (state != S_DONE);

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: two instances (0 and 3 wait states), byte-level memory
// model, expected responses queued at issue and checked when MemReadyM pulses.
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic [2:0]  f3    [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [31:0] rd    [2];
  logic        rdy   [2];
  logic        err   [2];
  logic        stall [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .MemReqM(req[0]), .MemWriteM(we[0]), .Funct3M(f3[0]),
    .ALUResultM(addr[0]), .WriteDataM(wd[0]), .ReadDataM(rd[0]), .MemReadyM(rdy[0]),
    .ErrM(err[0]), .StallM(stall[0]));

  dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u3 (
    .clk(clk), .reset(reset), .MemReqM(req[1]), .MemWriteM(we[1]), .Funct3M(f3[1]),
    .ALUResultM(addr[1]), .WriteDataM(wd[1]), .ReadDataM(rd[1]), .MemReadyM(rdy[1]),
    .ErrM(err[1]), .StallM(stall[1]));

  // reference model: byte-addressed memory per instance, last load value
  logic [7:0]  mb [int];
  logic [31:0] last_rd [2];
  logic [33:0] exp_q [$];   // {instance, err, ReadDataM}

  function automatic int key(input int s, input logic [31:0] a);
    return s * (1 << 20) + int'(a % 32'(4 * DEPTH));
  endfunction

  function automatic void model(input int s, input bit st, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] d,
                                output bit e, output logic [31:0] r);
    int n;
    longint v;
    case (f)
      3'b000:  e = 1'b0;
      3'b001:  e = a[0];
      3'b010:  e = (a[1:0] != 2'b00);
      3'b100:  e = st;
      3'b101:  e = st || a[0];
      default: e = 1'b1;
    endcase
    n = 1 << f[1:0];
    if (e) begin
      last_rd[s] = 32'h0;
    end else if (st) begin
      for (int i = 0; i < n; i++) mb[key(s, a + 32'(i))] = d[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) begin
        int k;
        k = key(s, a + 32'(i));
        v |= longint'(mb.exists(k) ? mb[k] : 8'h00) << (8 * i);
      end
      if (!f[2] && v[8*n-1]) v |= -(longint'(1) << (8 * n));
      last_rd[s] = v[31:0];
    end
    r = last_rd[s];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // monitor: compare every completion against the oldest queued expectation
  always @(negedge clk) begin
    logic [33:0] ent;
    for (int k = 0; k < 2; k++) begin
      if (err[k] === 1'b1 && rdy[k] !== 1'b1) begin
        n_vec++; n_bad++;
        $display("FAIL err_without_ready: dut %0d ErrM=1 with MemReadyM=0", k);
      end
      if (rdy[k] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL spurious_ready: dut %0d ready with no access pending", k);
        end else begin
          ent = exp_q.pop_front();
          chk("ready_owner", 32'(k), {31'h0, ent[33]});
          chk("ErrM", {31'h0, err[k]}, {31'h0, ent[32]});
          chk("ReadDataM", rd[k], ent[31:0]);
        end
      end
    end
  end

  // one complete access, checking stall length and ready latency
  task automatic acc(input int s, input bit st, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d);
    bit e;
    logic [31:0] r;
    int ns, nc, ws;
    ws = (s == 1) ? 3 : 0;
    model(s, st, f, a, d, e, r);
    exp_q.push_back({s[0], e, r});
    @(posedge clk); #1;
    req[s] = 1'b1; we[s] = st; f3[s] = f; addr[s] = a; wd[s] = d;
    ns = 0; nc = 0;
    do begin
      @(negedge clk);
      nc++;
      if (stall[s]) ns++;
    end while (rdy[s] !== 1'b1 && nc < 20);
    req[s] = 1'b0;
    chk("ready_latency", 32'(nc), 32'(ws + 2));
    chk("stall_cycles", 32'(ns), 32'(ws + 1));
  endtask

  task automatic rand_phase(input int s, input int nops);
    logic [2:0]  f;
    logic [31:0] a;
    for (int w = 0; w < 16; w++) acc(s, 1'b1, F3_W, 32'(4 * w), $urandom);
    for (int i = 0; i < nops; i++) begin
      case ($urandom_range(0, 5))
        0: f = F3_B;
        1: f = F3_H;
        2: f = F3_W;
        3: f = F3_BU;
        4: f = F3_HU;
        default: f = 3'($urandom_range(0, 7));
      endcase
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a &= ~32'h3;
      if ($urandom_range(0, 1) == 1) a += 32'(4 * DEPTH) * 32'($urandom_range(1, 3));
      acc(s, ($urandom_range(0, 2) == 0), f, a, $urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; f3[k] = 3'b0; addr[k] = '0; wd[k] = '0;
      last_rd[k] = '0;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ReadDataM", rd[k], 32'h0);
      chk("reset_MemReadyM", {31'h0, rdy[k]}, 32'h0);
      chk("reset_ErrM", {31'h0, err[k]}, 32'h0);
      chk("reset_StallM", {31'h0, stall[k]}, 32'h0);
    end
    req[0] = 1'b1; #1;
    chk("stall_follows_req_in_reset", {31'h0, stall[0]}, 32'h1);
    req[0] = 1'b0;
    @(negedge clk) reset = 1'b0;

    // zero wait states: sizing, extension, lanes, errors
    acc(0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    chk("sw_no_err", {31'h0, err[0]}, 32'h0);
    acc(0, 1'b0, F3_W,  32'h10, 32'h0); chk("lw_10",  rd[0], 32'hDEADBEEF);
    acc(0, 1'b0, F3_B,  32'h13, 32'h0); chk("lb_13",  rd[0], 32'hFFFFFFDE);
    acc(0, 1'b0, F3_BU, 32'h13, 32'h0); chk("lbu_13", rd[0], 32'h000000DE);
    acc(0, 1'b0, F3_H,  32'h12, 32'h0); chk("lh_12",  rd[0], 32'hFFFFDEAD);
    acc(0, 1'b0, F3_HU, 32'h10, 32'h0); chk("lhu_10", rd[0], 32'h0000BEEF);
    acc(0, 1'b1, F3_B,  32'h11, 32'h55);
    chk("sb_keeps_rd", rd[0], 32'h0000BEEF);
    acc(0, 1'b0, F3_W,  32'h10, 32'h0); chk("lw_after_sb", rd[0], 32'hDEAD55EF);
    acc(0, 1'b0, F3_W,  32'h12, 32'h0);
    chk("lw_mis_err", {31'h0, err[0]}, 32'h1);
    chk("lw_mis_rd", rd[0], 32'h0);
    acc(0, 1'b1, F3_H,  32'h11, 32'hAAAA);
    chk("sh_mis_err", {31'h0, err[0]}, 32'h1);
    acc(0, 1'b0, F3_W,  32'h10, 32'h0); chk("lw_after_bad_sh", rd[0], 32'hDEAD55EF);
    acc(0, 1'b0, 3'b011, 32'h10, 32'h0);
    chk("f3_011_err", {31'h0, err[0]}, 32'h1);
    acc(0, 1'b1, F3_BU, 32'h10, 32'h77);
    chk("sbu_err", {31'h0, err[0]}, 32'h1);

    // three wait states: back-to-back loads, then reset during a store's wait
    acc(1, 1'b1, F3_W, 32'h20, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) acc(1, 1'b0, F3_W, 32'h20, 32'h0);
    chk("ws3_lw_20", rd[1], 32'hCAFEF00D);
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b1; f3[1] = F3_W; addr[1] = 32'h20; wd[1] = 32'h12345678;
    @(negedge clk); @(negedge clk);
    reset = 1'b1; last_rd[0] = '0; last_rd[1] = '0;
    #1;
    chk("midrst_ReadDataM", rd[1], 32'h0);
    chk("midrst_MemReadyM", {31'h0, rdy[1]}, 32'h0);
    chk("midrst_StallM", {31'h0, stall[1]}, 32'h1);
    req[1] = 1'b0;
    @(negedge clk) reset = 1'b0;
    acc(1, 1'b0, F3_W, 32'h20, 32'h0);
    chk("after_rst_lw_20", rd[1], 32'hCAFEF00D);
    acc(1, 1'b0, F3_W, 32'h20 + 32'(4 * DEPTH), 32'h0);
    chk("alias_lw_20", rd[1], 32'hCAFEF00D);

    rand_phase(0, 60);
    rand_phase(1, 40);

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
